// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: registered single-cycle ops plus iterative mulu/divu.
// Optional divider enabled by defining ALU_MC_DIV_EN.
module alu_mc #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   alucontrol,
  input  logic [n-1:0] srca,
  input  logic [n-1:0] srcb,
  output logic         ready,
  output logic         done,
  output logic [n-1:0] aluout,
  output logic [n-1:0] hi,
  output logic         zero
);

  localparam int unsigned SW = $clog2(n);
  localparam int unsigned CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
`ifdef ALU_MC_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1001;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef ALU_MC_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [2*n-1:0]   r_acc, w_acc_nxt;
  logic [n-1:0]     r_b, w_b_nxt;
  logic             r_eq, w_eq_nxt;
  logic             r_ready;
  logic             r_done, w_done_nxt;
  logic [n-1:0]     r_aluout, w_aluout_nxt;
  logic [n-1:0]     r_hi, w_hi_nxt;
  logic             r_zero, w_zero_nxt;

  logic [n-1:0]     w_single, w_single_hi;
  logic [n:0]       w_madd;
  logic [2*n-1:0]   w_mul_step;
  logic             w_last;

  // Single-cycle result, also covering unsupported ops and divide-by-zero.
  always_comb begin
    w_single    = '0;
    w_single_hi = '0;
    case (alucontrol)
      OP_ADD: w_single = srca + srcb;
      OP_SUB: w_single = srca - srcb;
      OP_SLL: w_single = srca << srcb[SW-1:0];
      OP_SRL: w_single = srca >> srcb[SW-1:0];
      OP_AND: w_single = srca & srcb;
      OP_OR:  w_single = srca | srcb;
      OP_XOR: w_single = srca ^ srcb;
      OP_SLT: w_single = {(n-1)'(0), ($signed(srca) < $signed(srcb))};
`ifdef ALU_MC_DIV_EN
      OP_DIVU: begin
        w_single    = '1;
        w_single_hi = srca;
      end
`endif
      default: w_single = '0;
    endcase
  end

  // Shift-add step: accumulator is {partial product, remaining multiplier}.
  assign w_madd     = {1'b0, r_acc[2*n-1:n]} + (r_acc[0] ? {1'b0, r_b} : (n+1)'(0));
  assign w_mul_step = {w_madd, r_acc[n-1:1]};
  assign w_last     = (r_cnt == CW'(n - 1));

`ifdef ALU_MC_DIV_EN
  logic [n:0]     w_dtop, w_dsub;
  logic           w_qbit;
  logic [2*n-1:0] w_div_step;

  // Restoring step: accumulator is {remainder, dividend/quotient}.
  assign w_dtop     = r_acc[2*n-1:n-1];
  assign w_dsub     = w_dtop - {1'b0, r_b};
  assign w_qbit     = (w_dtop >= {1'b0, r_b});
  assign w_div_step = {(w_qbit ? w_dsub[n-1:0] : w_dtop[n-1:0]), r_acc[n-2:0], w_qbit};
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_nxt    = r_acc;
    w_b_nxt      = r_b;
    w_eq_nxt     = r_eq;
    w_aluout_nxt = r_aluout;
    w_hi_nxt     = r_hi;
    w_zero_nxt   = r_zero;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_eq_nxt  = (srca == srcb);
          w_b_nxt   = srcb;
          w_cnt_nxt = '0;
          if (alucontrol == OP_MULU) begin
            w_state_nxt = S_MUL;
            w_acc_nxt   = {{n{1'b0}}, srca};
          end
`ifdef ALU_MC_DIV_EN
          else if (alucontrol == OP_DIVU && srcb != '0) begin
            w_state_nxt = S_DIV;
            w_acc_nxt   = {{n{1'b0}}, srca};
          end
`endif
          else begin
            w_aluout_nxt = w_single;
            w_hi_nxt     = w_single_hi;
            w_zero_nxt   = (srca == srcb);
            w_done_nxt   = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_acc_nxt = w_mul_step;
        if (w_last) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_aluout_nxt = w_mul_step[n-1:0];
          w_hi_nxt     = w_mul_step[2*n-1:n];
          w_zero_nxt   = r_eq;
          w_done_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`ifdef ALU_MC_DIV_EN
      S_DIV: begin
        w_acc_nxt = w_div_step;
        if (w_last) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_aluout_nxt = w_div_step[n-1:0];
          w_hi_nxt     = w_div_step[2*n-1:n];
          w_zero_nxt   = r_eq;
          w_done_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_eq     <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_aluout <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc    <= w_acc_nxt;
      r_b      <= w_b_nxt;
      r_eq     <= w_eq_nxt;
      r_ready  <= (w_state_nxt == S_IDLE);
      r_done   <= w_done_nxt;
      r_aluout <= w_aluout_nxt;
      r_hi     <= w_hi_nxt;
      r_zero   <= w_zero_nxt;
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign aluout = r_aluout;
  assign hi     = r_hi;
  assign zero   = r_zero;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (n=32); divu expectations follow ALU_MC_DIV_EN.
module tb_alu_mc;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   alucontrol;
  logic [N-1:0] srca, srcb;
  logic         ready, done, zero;
  logic [N-1:0] aluout, hi;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .alucontrol(alucontrol),
    .srca(srca), .srcb(srcb), .ready(ready), .done(done),
    .aluout(aluout), .hi(hi), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op and let the next rising edge accept it.
  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    start = 1'b1; alucontrol = op; srca = a; srcb = b;
    tick();
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] exp_lo,
                              input logic [N-1:0] exp_hi, input logic exp_z);
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_aluout"}, 64'(aluout), 64'(exp_lo));
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_zero"}, 64'(zero), 64'(exp_z));
  endtask

  initial begin
    int lat;
    int done_seen;
    reset = 1'b1; start = 1'b0; alucontrol = 4'h0; srca = '0; srcb = '0;
    tick(); tick();
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_aluout", 64'(aluout), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_zero", 64'(zero), 64'(0));
    reset = 1'b0;
    tick();

    issue(4'b0000, 32'hFFFF_FFFF, 32'h0000_0001);
    check_result("add_wrap", 32'h0, 32'h0, 1'b0);
    tick();
    chk("add_done_pulse", 64'(done), 64'(0));
    chk("add_hold", 64'(aluout), 64'(0));

    issue(4'b0001, 32'd5, 32'd5);
    check_result("sub_eq", 32'h0, 32'h0, 1'b1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    check_result("slt_neg", 32'h1, 32'h0, 1'b0);
    issue(4'b0010, 32'h1, 32'h0000_0024);
    check_result("sll", 32'h10, 32'h0, 1'b0);
    issue(4'b0011, 32'h8000_0000, 32'h0000_003F);
    check_result("srl", 32'h1, 32'h0, 1'b0);
    issue(4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00);
    check_result("and", 32'h00F0_1200, 32'h0, 1'b0);
    issue(4'b1111, 32'h1234_5678, 32'h1234_5678);
    check_result("unsup", 32'h0, 32'h0, 1'b1);

    // mulu with an ignored mid-flight start carrying different operands
    issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 32; i++) begin
      chk("mul_busy_ready", 64'(ready), 64'(0));
      chk("mul_busy_done", 64'(done), 64'(0));
      if (i == 5) begin
        start = 1'b1; alucontrol = 4'b0000; srca = 32'd7; srcb = 32'd8;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check_result("mulu_max", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    chk("mulu_ready", 64'(ready), 64'(1));
    tick();
    chk("mulu_no_extra", 64'(done), 64'(0));

    issue(4'b1000, 32'd12345, 32'd678);
    lat = 1;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("mulu_lat", 64'(lat), 64'(33));
    check_result("mulu_small", 32'd8369910, 32'h0, 1'b0);

`ifdef ALU_MC_DIV_EN
    issue(4'b1001, 32'd100, 32'd7);
    lat = 1;
    while (!done && lat < 40) begin tick(); lat++; end
    chk("divu_lat", 64'(lat), 64'(33));
    check_result("divu", 32'd14, 32'd2, 1'b0);
    issue(4'b1001, 32'd9, 32'd0);
    check_result("divu_by0", 32'hFFFF_FFFF, 32'd9, 1'b0);
`else
    issue(4'b1001, 32'd100, 32'd7);
    check_result("divu_off", 32'h0, 32'h0, 1'b0);
    chk("divu_off_ready", 64'(ready), 64'(1));
`endif

    // leave nonzero outputs, then reset mid-mulu
    issue(4'b0101, 32'h1, 32'h1);
    check_result("or_pre_rst", 32'h1, 32'h0, 1'b1);
    issue(4'b1000, 32'd3, 32'd4);
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    #2;
    chk("midrst_ready", 64'(ready), 64'(1));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_aluout", 64'(aluout), 64'(0));
    chk("midrst_hi", 64'(hi), 64'(0));
    chk("midrst_zero", 64'(zero), 64'(0));
    #2;
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) done_seen++;
    end
    chk("midrst_no_done", 64'(done_seen), 64'(0));
    issue(4'b0000, 32'd2, 32'd3);
    check_result("add_after_rst", 32'd5, 32'h0, 1'b0);

    // back-to-back issue in the done cycle
    issue(4'b0101, 32'hF0, 32'h0F);
    check_result("b2b_or", 32'hFF, 32'h0, 1'b0);
    chk("b2b_ready", 64'(ready), 64'(1));
    issue(4'b0110, 32'hFF, 32'h0F);
    check_result("b2b_xor", 32'hF0, 32'h0, 1'b0);
    tick();
    chk("b2b_end", 64'(done), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised integer ALU for the MIPS datapath. It replaces the purely combinational ALU where the core needs multiply and divide. Single-cycle ops are registered and return one cycle after issue. Iterative unsigned multiply and divide run for `n` cycles. The control unit stalls on `ready` and captures results on `done`.

## Interface
- `n`, default 32: operand/result width; must be ≥ 4 and a power of two.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: issue request; accepted only when `ready`=1.
- `alucontrol` in 4: operation code, sampled on acceptance.
- `srca` in n: operand A, sampled on acceptance.
- `srcb` in n: operand B, sampled on acceptance.
- `ready` out 1: unit idle and able to accept `start`.
- `done` out 1: one-cycle pulse; `aluout`/`hi`/`zero` valid from this cycle on.
- `aluout` out n: primary result (low product, quotient).
- `hi` out n: high product or remainder; 0 for single-cycle ops.
- `zero` out 1: 1 when the captured `srca`==`srcb` (branch compare).

## Operation
- Opcodes:
  - 0000 add; 0001 sub; 0010 sll; 0011 srl.
  - 0100 and; 0101 or; 0110 xor; 0111 slt (signed, result 0 or 1).
  - 1000 mulu; 1001 divu; 1010–1111 unsupported.
- Shift amount is `srcb[log2(n)-1:0]`; upper bits are ignored.
- Add/sub wrap modulo 2^n. No overflow flag.
- States:
  - IDLE: `ready`=1.
  - MUL: iterating, `ready`=0.
  - DIV: iterating, `ready`=0.
- IDLE + `start`, single-cycle or unsupported op:
  - result registered at this edge; stay IDLE.
  - `done`=1 next cycle.
  - Unsupported ops give `aluout`=0, `hi`=0.
- IDLE + `start` + mulu:
  - go to MUL, load a `2n`-bit accumulator, iteration counter = 0.
  - Each cycle: shift-add one multiplier bit.
  - After the `n`th iteration, return to IDLE with {`hi`,`aluout`} = full `2n`-bit product and `done`=1.
- IDLE + `start` + divu:
  - go to DIV and run restoring division, one quotient bit per cycle, `n` cycles.
  - `aluout` = quotient, `hi` = remainder.
- divu with `srcb`==0:
  - takes the single-cycle path, no DIV entry.
  - `aluout` = all ones, `hi` = `srca`.
- `start` while `ready`=0 is ignored. Operands are not re-sampled.
- Outputs hold their last values until the next `done`.
- `done` is asserted in an IDLE cycle, so `start` may be accepted in the same cycle as `done` (back-to-back issue).
- Reset, at any time including mid-iteration:
  - state IDLE, `ready`=1, `done`=0.
  - `aluout`=0, `hi`=0, `zero`=0, counter=0.
  - In-flight operation discarded; no `done`.

## Timing
- Issue at edge k (`start`&&`ready`). Latencies:
  - single-cycle/unsupported/div-by-zero: `done` in cycle k+1.
  - mulu/divu: `done` in cycle k+n+1 (`ready`=0 cycles k+1..k+n).
- `zero` updates with `done` and reflects operands captured at edge k.
- Throughput: one single-cycle op per clock; one mul/div per n+1 clocks.
- Counter is `log2(n)+1` bits wide; terminal count is `n-1`. No wrap beyond.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- Macro `ALU_MC_DIV_EN`:
  - defined: divu (1001) is implemented as above, including DIV state and divide-by-zero fast path.
  - undefined: DIV state, divider datapath and remainder logic are omitted. 1001 is treated as unsupported: 1-cycle latency, `aluout`=0, `hi`=0.
- mulu and all single-cycle ops are always present.

## Test plan
- n=32, add 0xFFFFFFFF+0x00000001 -> `done` at k+1, `aluout`=0x00000000, `hi`=0, `zero`=0; sub 5−5 -> `aluout`=0, `zero`=1.
- slt 0xFFFFFFFF vs 0x00000001 -> `aluout`=1; sll 0x1 by `srcb`=0x00000024 (shift 4) -> 0x10.
- mulu 0xFFFFFFFF×0xFFFFFFFF -> `ready`=0 for 32 cycles, `done` at k+33, `hi`=0xFFFFFFFE, `aluout`=0x00000001; `start`+add pulsed mid-operation is ignored.
- With `ALU_MC_DIV_EN`: divu 100÷7 -> `done` at k+33, `aluout`=14, `hi`=2; divu 9÷0 -> `done` at k+1, `aluout`=0xFFFFFFFF, `hi`=9. Without the macro: divu 100÷7 -> `done` at k+1, `aluout`=0, `hi`=0.
- Reset asserted at cycle k+10 of a mulu -> immediately `ready`=1, all outputs 0, no `done`. The next add 2+3 -> `aluout`=5 at +1.
- Back-to-back: issue or 0xF0|0x0F, then `start` xor 0xFF^0x0F in the `done` cycle -> consecutive `done` pulses with `aluout`=0xFF then 0xF0.
